// File: rtl/cmd_uart_responder_pkg.sv
// Shared types and constants for the remote command link endpoint and its command processor.
package cmd_uart_responder_pkg;

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } asm_state_e;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam logic [7:0] POS_ACK = 8'hA5;

endpackage

// File: rtl/cmd_uart_responder_uart_tx_byte.sv
// 8N1 byte serializer: TX drops 1 clock after an accepted trmt, frame is 10*BAUD_DIV clocks.
// trmt while busy is ignored; tx_done holds from the end of the stop bit until the next accepted trmt.
module uart_tx_byte
  import cmd_uart_responder_pkg::*;
#(
  parameter int BAUD_DIV = 5208
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tx_done_q, tx_done_d;

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    tx_done_d = tx_done_q;
    case (state_q)
      IDLE: begin
        if (trmt) begin
          state_d   = START;
          shift_d   = tx_data;
          baud_d    = '0;
          tx_d      = 1'b0;
          tx_done_d = 1'b0;
        end
      end
      START, DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (state_q == START) begin
            state_d = DATA;
            bit_d   = '0;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          state_d   = IDLE;
          tx_done_d = 1'b1;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_done = tx_done_q;

endmodule

// File: rtl/cmd_uart_responder.sv
// Robot-side command link: two RX bytes (high first) become a 16-bit cmd with cmd_rdy, 1 clock after the low stop sample.
// No backpressure: an unconsumed cmd is overwritten by the next one; the response path is the uart_tx_byte shifter.
module cmd_uart_responder
  import cmd_uart_responder_pkg::*;
#(
  parameter int BAUD_DIV = 5208,
  parameter int TMO_CLKS = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        trmt,
  output logic        tx_done
);

  localparam int BW = $clog2(BAUD_DIV);
  localparam int TW = $clog2(TMO_CLKS + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CLKS);

  logic          rx_meta_q, rx_sync_q, rx_prev_q;
  uart_state_e   rx_state_q, rx_state_d;
  logic [BW-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          byte_vld_q, byte_vld_d;
  logic          frm_err_q, frm_err_d;
  logic          start_det;

  asm_state_e    asm_q, asm_d;
  logic [7:0]    hi_q, hi_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;

  assign start_det = (rx_state_q == IDLE) && rx_prev_q && !rx_sync_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    byte_vld_d = 1'b0;
    frm_err_d  = 1'b0;
    case (rx_state_q)
      IDLE: begin
        if (start_det) begin
          rx_state_d = START;
          rx_baud_d  = '0;
        end
      end
      START: begin
        // A high line at the start-bit midpoint was a glitch, not a frame.
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? IDLE : DATA;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = STOP;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      STOP: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_state_d = IDLE;
          byte_vld_d = rx_sync_q;
          frm_err_d  = !rx_sync_q;
        end else begin
          rx_baud_d = rx_baud_q + 1'b1;
        end
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    asm_d     = asm_q;
    hi_d      = hi_q;
    tmo_d     = tmo_q;
    cmd_d     = cmd_q;
    cmd_rdy_d = cmd_rdy_q;
    if (clr_cmd_rdy || (asm_q == WAIT_HI && start_det)) cmd_rdy_d = 1'b0;
    if (frm_err_q) begin
      asm_d = WAIT_HI;
    end else if (byte_vld_q) begin
      if (asm_q == WAIT_HI) begin
        hi_d  = rx_shift_q;
        tmo_d = '0;
        asm_d = WAIT_LO;
      end else begin
        cmd_d     = {hi_q, rx_shift_q};
        cmd_rdy_d = 1'b1;
        asm_d     = WAIT_HI;
      end
    end else if (asm_q == WAIT_LO && rx_state_q == IDLE) begin
      // Counter stops at the limit, which is also the point the half command is dropped.
      if (tmo_q == TMO_LAST) begin
        asm_d = WAIT_HI;
        hi_d  = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_vld_q <= 1'b0;
      frm_err_q  <= 1'b0;
      asm_q      <= WAIT_HI;
      hi_q       <= '0;
      tmo_q      <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
    end else begin
      rx_meta_q  <= RX;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      byte_vld_q <= byte_vld_d;
      frm_err_q  <= frm_err_d;
      asm_q      <= asm_d;
      hi_q       <= hi_d;
      tmo_q      <= tmo_d;
      cmd_q      <= cmd_d;
      cmd_rdy_q  <= cmd_rdy_d;
    end
  end

  assign cmd     = cmd_q;
  assign cmd_rdy = cmd_rdy_q;

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .trmt   (trmt),
    .tx_data(resp),
    .tx     (TX),
    .tx_done(tx_done)
  );

endmodule

// File: tb/tb_cmd_uart_responder.sv
// Scoreboard bench: remote-controller stimulus pushes expected commands/responses, monitors decode DUT outputs.
`timescale 1ns/1ps
module tb_cmd_uart_responder;
  import cmd_uart_responder_pkg::*;

  localparam int BD     = 16;
  localparam int TMO    = 2000;
  localparam int RX_LAT = 155;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic [7:0]  resp;
  logic        trmt;
  logic        tx_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [15:0] exp_cmd[$];
  int          exp_t[$];
  logic [7:0]  exp_resp[$];

  cmd_uart_responder #(.BAUD_DIV(BD), .TMO_CLKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp(resp), .trmt(trmt), .tx_done(tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Remote controller: one 8N1 byte, optionally marking the start as the command-latency reference.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input bit mark);
    @(negedge clk);
    RX = 1'b0;
    if (mark) exp_t.push_back(cyc + RX_LAT);
    repeat (BD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      repeat (BD) @(negedge clk);
    end
    RX = stop_bit;
    repeat (BD) @(negedge clk);
    RX = 1'b1;
  endtask

  task automatic send_cmd(input logic [15:0] c);
    exp_cmd.push_back(c);
    send_byte(c[15:8], 1'b1, 1'b0);
    send_byte(c[7:0], 1'b1, 1'b1);
  endtask

  task automatic send_resp(input logic [7:0] b, input bit retrig);
    int  k;
    bit  seen;
    @(negedge clk);
    resp = b;
    trmt = 1'b1;
    exp_resp.push_back(b);
    @(negedge clk);
    trmt = 1'b0;
    resp = ~b;
    chk("tx_start_low", TX, 0);
    chk("tx_done_cleared", tx_done, 0);
    k = 0;
    seen = 0;
    while (!seen && k < 400) begin
      @(negedge clk);
      k++;
      if (retrig && k == 50) begin
        resp = 8'h00;
        trmt = 1'b1;
      end else begin
        trmt = 1'b0;
      end
      if (tx_done) seen = 1;
    end
    chk("tx_done_latency", k, 10 * BD);
  endtask

  // Command processor: consume every command and check value, latency and clear.
  initial begin : cmd_mon
    logic [15:0] e;
    int          et;
    clr_cmd_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && cmd_rdy === 1'b1) begin
        if (exp_cmd.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_cmd got %0h want none", cmd);
        end else begin
          e = exp_cmd.pop_front();
          chk("cmd_value", cmd, e);
          if (exp_t.size() != 0) begin
            et = exp_t.pop_front();
            checks++;
            if (cyc < et - 2 || cyc > et + 2) begin
              errors++;
              $display("FAIL cmd_rdy_latency got cycle %0d want %0d", cyc, et);
            end
          end
        end
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("cmd_rdy_clr", cmd_rdy, 0);
      end
    end
  end

  task automatic tx_wait(input int n, inout bit ok);
    repeat (n) begin
      @(negedge clk);
      if (rst_n !== 1'b1) ok = 0;
    end
  endtask

  // Remote controller receiver: mid-bit sampling of TX; frames cut by reset are discarded.
  initial begin : tx_mon
    logic [7:0] b;
    logic       st, sp;
    bit         ok;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && TX === 1'b0) begin
        ok = 1;
        tx_wait(BD / 2, ok);
        st = TX;
        for (int i = 0; i < 8; i++) begin
          tx_wait(BD, ok);
          b[i] = TX;
        end
        tx_wait(BD, ok);
        sp = TX;
        if (ok) begin
          if (exp_resp.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tx_frame got %0h want none", b);
          end else begin
            chk("tx_frame", {sp, b, st}, {1'b1, exp_resp.pop_front(), 1'b0});
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] c;
    rst_n = 1'b0;
    RX    = 1'b1;
    trmt  = 1'b0;
    resp  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_tx", TX, 1);
    chk("rst_cmd", cmd, 0);
    chk("rst_cmd_rdy", cmd_rdy, 0);
    chk("rst_tx_done", tx_done, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    send_cmd(16'h4BF4);
    repeat (40) @(negedge clk);

    send_resp(POS_ACK, 1'b1);
    repeat (20) @(negedge clk);

    send_byte(8'h4B, 1'b1, 1'b0);
    repeat (2500) @(negedge clk);
    send_cmd(16'h2000);
    repeat (40) @(negedge clk);

    send_byte(8'h4B, 1'b0, 1'b0);
    repeat (32) @(negedge clk);
    send_cmd(16'h1234);
    repeat (40) @(negedge clk);

    @(negedge clk);
    RX = 1'b0;
    repeat (4) @(negedge clk);
    RX = 1'b1;
    repeat (200) @(negedge clk);

    fork
      send_cmd(16'hC3A7);
      send_resp(POS_ACK, 1'b0);
    join
    repeat (40) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      c = 16'($urandom);
      if (i % 2 == 1) begin
        fork
          send_cmd(c);
          send_resp(8'($urandom), 1'b0);
        join
      end else begin
        send_cmd(c);
      end
      repeat ($urandom_range(30, 5)) @(negedge clk);
    end
    repeat (40) @(negedge clk);

    fork
      begin
        @(negedge clk);
        resp = POS_ACK;
        trmt = 1'b1;
        @(negedge clk);
        trmt = 1'b0;
      end
      begin
        @(negedge clk);
        RX = 1'b0;
        repeat (40) @(negedge clk);
      end
    join
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_tx", TX, 1);
    chk("midrst_cmd_rdy", cmd_rdy, 0);
    chk("midrst_cmd", cmd, 0);
    chk("midrst_tx_done", tx_done, 0);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    send_cmd(16'h0002);
    repeat (300) @(negedge clk);

    chk("cmd_queue_drained", exp_cmd.size(), 0);
    chk("resp_queue_drained", exp_resp.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_uart_responder.md
# cmd_uart_responder

Robot-side endpoint of the remote command link. It receives a 16-bit command from the remote controller as two 8N1 UART bytes, high byte first, and presents the command to the command processor with a ready flag. It also serializes the 8-bit response byte, such as the positive ack `8'hA5`, back to the remote controller. It sits between the `RX`/`TX` pins of the top level and the command processor.

## Interface
- `BAUD_DIV`, default 5208: clocks per bit (50 MHz / 9600 baud); minimum 8.
- `TMO_CLKS`, default 1,000,000: maximum clocks allowed between the end of the high byte and the start of the low byte.
- `clk`  in  1  system clock; the block uses this single clock only.
- `rst_n`  in  1  synchronous, active-low reset.
- `RX`  in  1  serial in from the remote controller; asynchronous to `clk`.
- `TX`  out  1  serial out to the remote controller.
- `cmd`  out  16  last assembled command.
- `cmd_rdy`  out  1  high while `cmd` holds a new, unconsumed command.
- `clr_cmd_rdy`  in  1  one-cycle pulse from the command processor that consumes the command.
- `resp`  in  8  response byte, sampled when `trmt` is high.
- `trmt`  in  1  pulse that starts transmission of `resp`.
- `tx_done`  out  1  high once the response stop bit has completed.

## Operation
- **RX synchronizer:** `RX` passes through two flops, both reset to 1, before any use.
- **RX bit timing:** a falling edge while idle starts reception. The first sample is taken `BAUD_DIV/2` clocks after the edge (start-bit midpoint). Each following sample is taken every `BAUD_DIV` clocks: 8 data bits LSB first, then the stop bit.
- **False start:** if the start-bit midpoint sample reads 1, the receiver returns to idle and delivers no byte.
- **Framing error:** a stop-bit sample of 0 discards the byte and forces the assembler to `WAIT_HI`.
- **Assembler FSM, state `WAIT_HI`:** a valid byte is stored as the high byte, the timeout counter is cleared, and the FSM moves to `WAIT_LO`.
- **Assembler FSM, state `WAIT_LO`:** a valid byte loads `cmd = {hi, byte}`, sets `cmd_rdy`, and returns to `WAIT_HI`.
- **Inter-byte timeout:** the counter runs only in `WAIT_LO` while the receiver is idle. At `TMO_CLKS` the FSM returns to `WAIT_HI`, the stored high byte is dropped, and `cmd_rdy` is not changed.
- **`cmd_rdy` clear:** `cmd_rdy` clears on `clr_cmd_rdy`, or on detection of a new start bit while in `WAIT_HI`. If a set and a clear occur in the same cycle, the set wins.
- **TX shifter:** `trmt` while idle loads the 10-bit frame `{1, resp, 0}` and shifts it out LSB first, one bit every `BAUD_DIV` clocks. `TX` idles at 1.
- **TX busy behaviour:** `trmt` while a frame is in progress is ignored, and `resp` is not re-sampled.
- **`tx_done`:** clears on an accepted `trmt`; sets at the end of the stop bit and stays set until the next accepted `trmt`.
- **RX/TX concurrency:** the receive and transmit paths are fully independent and may be active at the same time.

## Timing
- **Reset values:** `TX`=1, `cmd`=0, `cmd_rdy`=0, `tx_done`=0. Both FSMs go to idle and the assembler goes to `WAIT_HI`.
- **Reset mid-frame:** any frame in progress in either direction is aborted with no output.
- **`cmd` stability:** `cmd` changes only in the cycle that sets `cmd_rdy`.
- **Command latency:** `cmd_rdy` rises 1 clock after the low-byte stop-bit sample. That is about 9.5 bit times after that byte's start edge, plus 2 synchronizer clocks and 1 register clock.
- **TX latency:** `TX` goes low 1 clock after the `trmt` pulse. The full frame lasts exactly 10×`BAUD_DIV` clocks.
- **Counter widths:** the baud counter uses `$clog2(BAUD_DIV)` bits. The timeout counter uses `$clog2(TMO_CLKS+1)` bits and saturates; it does not wrap.

## Structure
- **Shared package:** holds the `WAIT_HI`/`WAIT_LO` enum, the RX and TX state enums (`IDLE`, `START`, `DATA`, `STOP`), and the `POS_ACK = 8'hA5` constant shared with the command processor and the benches.
- **Sub-module:** `uart_tx_byte` contains the TX shifter and is reused by other links. RX and the assembler stay in this module.

## Test plan
All scenarios run with `BAUD_DIV`=16 and `TMO_CLKS`=2000.
- **Basic command:** remote sends `16'h4BF4` → `cmd`=`16'h4BF4` and `cmd_rdy` goes high 1 clock after the second stop-bit sample. `clr_cmd_rdy` → `cmd_rdy`=0 on the next clock.
- **Response:** `trmt` with `resp`=`8'hA5` → remote receives `8'hA5`, and `tx_done` rises exactly 160 clocks after `trmt`. A second `trmt` at clock 50 produces no change to the frame.
- **Timeout:** send byte `8'h4B`, idle 2500 clocks, then send `8'h20` and `8'h00` → `cmd`=`16'h2000`, and the `8'h4B` never appears in `cmd`.
- **Framing error:** send `8'h4B` with stop bit=0, then `8'h12`, `8'h34` → `cmd`=`16'h1234`, and `cmd_rdy` pulses only once.
- **Glitch and full duplex:** a 4-clock low glitch on `RX` produces no byte. A command received while `8'hA5` is being transmitted leaves both transfers correct.
- **Reset mid-frame:** `rst_n`=0 mid-frame in both directions → `TX`=1, `cmd_rdy`=0, `cmd`=0. The next command `16'h0002` is received correctly.
